// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: default geometry of the
// `layers` cfg bus and descriptor, plus the state register type.
package layer_sequencer_pkg;

  localparam int unsigned LS_CFG_DWIDTH = 32;
  localparam int unsigned LS_CFG_AWIDTH = 5;
  localparam int unsigned LS_CFG_NB     = 8;
  localparam int unsigned LS_CNT_WIDTH  = 16;

  typedef logic [2:0] state_t;

  // Total descriptor width: CFG_NB config words followed by the result target.
  function automatic int unsigned desc_width(input int unsigned nb,
                                             input int unsigned dw,
                                             input int unsigned cw);
    return nb * dw + cw;
  endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Per-layer control sequencer: replays a descriptor's config words onto the
// `layers` cfg bus, requests the kernel load, enables the image stream and
// pulses done once the last image beat and the last expected result are in.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH = LS_CFG_DWIDTH,
  parameter int unsigned CFG_AWIDTH = LS_CFG_AWIDTH,
  parameter int unsigned CFG_NB     = LS_CFG_NB,
  parameter int unsigned CNT_WIDTH  = LS_CNT_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [CFG_NB*CFG_DWIDTH+CNT_WIDTH-1:0]  cmd_data,
  input  logic                                    cmd_val,
  output logic                                    cmd_rdy,
  output logic [CFG_DWIDTH-1:0]                   cfg_data,
  output logic [CFG_AWIDTH-1:0]                   cfg_addr,
  output logic                                    cfg_valid,
  input  logic                                    kernel_rdy,
  output logic                                    ker_req,
  input  logic                                    ker_ack,
  output logic                                    img_go,
  input  logic                                    image_val,
  input  logic                                    image_rdy,
  input  logic                                    image_last,
  input  logic                                    result_val,
  input  logic                                    result_rdy,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err,
  output logic [CNT_WIDTH-1:0]                    img_cnt
);

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CFG   = 3'd1;
  localparam state_t S_KER   = 3'd2;
  localparam state_t S_IMG   = 3'd3;
  localparam state_t S_DRAIN = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  localparam int unsigned           DESC_W   = CFG_NB * CFG_DWIDTH;
  localparam logic [CFG_AWIDTH-1:0] LAST_IDX = CFG_AWIDTH'(CFG_NB - 1);

  state_t                  r_state;
  logic [DESC_W-1:0]       r_desc;
  logic [CNT_WIDTH-1:0]    r_target;
  logic [CFG_AWIDTH-1:0]   r_idx;
  logic [CFG_AWIDTH-1:0]   r_cfg_addr;
  logic [CFG_DWIDTH-1:0]   r_cfg_data;
  logic                    r_cfg_valid;
  logic [CNT_WIDTH-1:0]    r_img_cnt;
  logic [CNT_WIDTH-1:0]    r_res_cnt;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_ker_req;
  logic                    w_img_hs;
  logic                    w_res_hs;
  logic                    w_res_phase;
  logic [CNT_WIDTH-1:0]    w_res_cnt_nx;
  logic                    w_res_met;
  logic                    w_err_set;
  logic [CFG_AWIDTH-1:0]   w_idx_nx;
  logic [CFG_DWIDTH-1:0]   w_word_nx;

  // Handshake decodes, saturating result count and error conditions.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && cmd_val;
    w_ker_req    = (r_state == S_KER) && kernel_rdy;
    w_img_hs     = image_val && image_rdy;
    w_res_hs     = result_val && result_rdy;
    w_res_phase  = (r_state == S_IMG) || (r_state == S_DRAIN);
    w_res_cnt_nx = r_res_cnt;
    if (w_res_phase && w_res_hs && (r_res_cnt != '1))
      w_res_cnt_nx = r_res_cnt + 1'b1;
    // Post-increment compare: a result landing with image_last completes at once.
    w_res_met    = (w_res_cnt_nx >= r_target);
    w_err_set    = (w_res_hs && !w_res_phase)
                || (w_img_hs && (r_state != S_IMG))
                || ((r_state == S_IMG) && w_img_hs && (r_img_cnt == '1))
                || ((r_state == S_IMG) && w_res_hs && (r_res_cnt >= r_target));
    w_idx_nx     = r_idx + 1'b1;
    w_word_nx    = r_desc[CFG_DWIDTH*int'(w_idx_nx) +: CFG_DWIDTH];
  end

  // Layer FSM, descriptor capture and registered cfg replay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_desc      <= '0;
      r_target    <= '0;
      r_idx       <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_CFG;
            r_desc      <= cmd_data[DESC_W-1:0];
            r_target    <= cmd_data[DESC_W +: CNT_WIDTH];
            r_idx       <= '0;
            // Word 0 comes straight from the command so cfg starts next cycle.
            r_cfg_valid <= 1'b1;
            r_cfg_addr  <= '0;
            r_cfg_data  <= cmd_data[CFG_DWIDTH-1:0];
          end
        end
        S_CFG: begin
          if (r_idx == LAST_IDX) begin
            r_cfg_valid <= 1'b0;
            r_state     <= S_KER;
          end else begin
            r_idx      <= w_idx_nx;
            r_cfg_addr <= w_idx_nx;
            r_cfg_data <= w_word_nx;
          end
        end
        S_KER: begin
          if (w_ker_req && ker_ack) r_state <= S_IMG;
        end
        S_IMG: begin
          if (w_img_hs && image_last) r_state <= w_res_met ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (w_res_met) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Image and result beat counters, cleared on each accepted descriptor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_img_cnt <= '0;
      r_res_cnt <= '0;
    end else if (w_accept) begin
      r_img_cnt <= '0;
      r_res_cnt <= '0;
    end else begin
      if ((r_state == S_IMG) && w_img_hs) r_img_cnt <= r_img_cnt + 1'b1;
      r_res_cnt <= w_res_cnt_nx;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign cmd_rdy   = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign img_go    = (r_state == S_IMG);
  assign done      = (r_state == S_DONE);
  assign ker_req   = w_ker_req;
  assign cfg_valid = r_cfg_valid;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign err       = r_err;
  assign img_cnt   = r_img_cnt;

endmodule
